md_unit: RTL

- Multi-cycle multiply/divide unit with its HI/LO register pair, in the EX stage directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage operand values (rs/rt after forwarding) and a decoded op.
- Runs MULT/MULTU/DIV/DIVU over a fixed latency and exposes HI/LO for MFHI/MFLO.
- Provides `busy` for the hazard unit, which stalls D when an md-class instruction meets `start|busy`.

---
 rtl/md_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with the architectural HI/LO pair.
// Results are computed at the start edge into a shadow pair and committed when the latency counter expires.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [31:0] r_hi, r_lo, r_shi, r_slo;
   logic [3:0]  r_cnt;
   logic        r_busy, r_commit;

   logic        w_accept, w_dsigned, w_neg_q, w_neg_r;
   logic [31:0] w_ua, w_ub, w_ub_nz, w_q, w_r, w_qs, w_rs;
   logic [63:0] w_mul_s, w_mul_u;

   assign w_accept = start & ~r_busy;

   assign w_mul_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
   assign w_mul_u = {32'd0, rs_val} * {32'd0, rt_val};

   // Signed divide runs on magnitudes so INT_MIN / -1 simply wraps.
   assign w_dsigned = (md_op == OP_DIV);
   assign w_ua      = (w_dsigned && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
   assign w_ub      = (w_dsigned && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
   assign w_ub_nz   = (w_ub == 32'd0) ? 32'd1 : w_ub;
   assign w_q       = w_ua / w_ub_nz;
   assign w_r       = w_ua % w_ub_nz;
   assign w_neg_q   = w_dsigned & (rs_val[31] ^ rt_val[31]);
   assign w_neg_r   = w_dsigned & rs_val[31];
   assign w_qs      = w_neg_q ? (~w_q + 32'd1) : w_q;
   assign w_rs      = w_neg_r ? (~w_r + 32'd1) : w_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_shi    <= '0;
         r_slo    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_commit <= 1'b0;
      end else if (w_accept) begin
         case (md_op)
            OP_MTHI: r_hi <= rs_val;
            OP_MTLO: r_lo <= rs_val;
            OP_MULT, OP_MULTU: begin
               {r_shi, r_slo} <= (md_op == OP_MULT) ? w_mul_s : w_mul_u;
               r_cnt          <= 4'(MULT_CYCLES);
               r_busy         <= 1'b1;
               r_commit       <= 1'b1;
            end
            OP_DIV, OP_DIVU: begin
               r_shi    <= w_rs;
               r_slo    <= w_qs;
               r_cnt    <= 4'(DIV_CYCLES);
               r_busy   <= 1'b1;
               // divide by zero still occupies the unit but leaves HI/LO untouched
               r_commit <= (rt_val != 32'd0);
            end
            default: ;
         endcase
      end else if (r_busy) begin
         if (r_cnt == 4'd1) begin
            if (r_commit) begin
               r_hi <= r_shi;
               r_lo <= r_slo;
            end
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_commit <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
